// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : ID-stage scoreboard that counts in-flight register writes
//                from issue to WB retirement and raises Stall on load-use
//                hazards and on pending-counter saturation.
//                Optional macro HAZARD_STALL_CNT_EN adds a 32-bit saturating
//                count of stall cycles (StallCnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [4:0]          ID_RegRs,
    input  logic [4:0]          ID_RegRt,
    input  logic                ID_UseRs,
    input  logic                ID_UseRt,
    input  logic                ID_Valid,
    input  logic                ID_RegWrite,
    input  logic [4:0]          ID_RegRd,
    input  logic                ID_MemRead,
    input  logic                WB_RegWrite,
    input  logic [4:0]          WBRegRd,
    input  logic                Flush,
    output logic                Stall,
    output logic                EX_MemRead,
    output logic [4:0]          EXRegRd,
    output logic [NUM_REGS-1:0] Busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]         StallCnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W+1:0] CNT_MAX_EXT = {2'b00, {CNT_W{1'b1}}};

    // Per-register outstanding-write counters; entry 0 is kept at zero.
    logic [CNT_W-1:0] pending     [NUM_REGS];
    logic [CNT_W-1:0] pending_nxt [NUM_REGS];

    // EX-stage shadow of the instruction that left ID last cycle.
    logic       ex_valid;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [4:0] ex_rd;

    logic stall_load_use;
    logic stall_sat;
    logic wb_hits_id;
    logic accept;
    logic ex_squash_write;

    // Apply one increment and up to two decrements, flooring at 0 and
    // clamping at the counter maximum.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             dec_a,
        input logic             dec_b
    );
        logic [CNT_W+1:0] up;
        logic [CNT_W+1:0] down;
        logic [CNT_W+1:0] diff;
        up   = {2'b00, cur} + {{(CNT_W+1){1'b0}}, inc};
        down = {{(CNT_W+1){1'b0}}, dec_a} + {{(CNT_W+1){1'b0}}, dec_b};
        diff = up - down;
        if (up <= down) begin
            next_count = '0;
        end else if (diff > CNT_MAX_EXT) begin
            next_count = CNT_MAX;
        end else begin
            next_count = diff[CNT_W-1:0];
        end
    endfunction

    // Hazard detection from current state: load-use and counter saturation.
    always_comb begin
        stall_load_use = 1'b0;
        stall_sat      = 1'b0;
        wb_hits_id     = WB_RegWrite && (WBRegRd == ID_RegRd);
        if (ex_valid && ex_memread && (ex_rd != 5'd0)) begin
            stall_load_use = (ID_UseRs && (ID_RegRs == ex_rd)) ||
                             (ID_UseRt && (ID_RegRt == ex_rd));
        end
        if (ID_RegWrite && (ID_RegRd != 5'd0)) begin
            stall_sat = (pending[ID_RegRd] == CNT_MAX) && !wb_hits_id;
        end
        Stall  = ID_Valid && !Flush && (stall_load_use || stall_sat);
        accept = ID_Valid && !Stall && !Flush;
        ex_squash_write = Flush && ex_valid && ex_regwrite;
    end

    // Next value of every pending counter from issue, retirement and squash.
    always_comb begin
        pending_nxt[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            pending_nxt[r] = next_count(
                pending[r],
                accept && ID_RegWrite && (ID_RegRd == 5'(r)),
                WB_RegWrite && (WBRegRd == 5'(r)),
                ex_squash_write && (ex_rd == 5'(r)));
        end
    end

    // Counter state register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pending[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pending[r] <= pending_nxt[r];
            end
        end
    end

    // EX shadow: capture the issued instruction, otherwise load a bubble.
    always_ff @(posedge clk_i) begin
        if (!rst_i || !accept) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_rd       <= 5'd0;
        end else begin
            ex_valid    <= 1'b1;
            ex_regwrite <= ID_RegWrite;
            ex_memread  <= ID_MemRead;
            ex_rd       <= ID_RegRd;
        end
    end

    // Visible EX fields and per-register busy flags.
    always_comb begin
        EX_MemRead = ex_memread;
        EXRegRd    = ex_rd;
        Busy       = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            Busy[r] = (pending[r] != '0);
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    // Saturating count of stall cycles; flush cycles never assert Stall.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            StallCnt <= 32'd0;
        end else if (Stall && (StallCnt != 32'hFFFF_FFFF)) begin
            StallCnt <= StallCnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Directed self-checking bench for hazard_scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  ID_RegRs, ID_RegRt, ID_RegRd, WBRegRd;
    logic        ID_UseRs, ID_UseRt, ID_Valid, ID_RegWrite, ID_MemRead;
    logic        WB_RegWrite, Flush;
    logic        Stall, EX_MemRead;
    logic [4:0]  EXRegRd;
    logic [31:0] Busy;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] StallCnt;
`endif

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ID_RegRs    (ID_RegRs),
        .ID_RegRt    (ID_RegRt),
        .ID_UseRs    (ID_UseRs),
        .ID_UseRt    (ID_UseRt),
        .ID_Valid    (ID_Valid),
        .ID_RegWrite (ID_RegWrite),
        .ID_RegRd    (ID_RegRd),
        .ID_MemRead  (ID_MemRead),
        .WB_RegWrite (WB_RegWrite),
        .WBRegRd     (WBRegRd),
        .Flush       (Flush),
        .Stall       (Stall),
        .EX_MemRead  (EX_MemRead),
        .EXRegRd     (EXRegRd),
        .Busy        (Busy)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .StallCnt    (StallCnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        ID_Valid = 0; ID_RegWrite = 0; ID_MemRead = 0; ID_RegRd = 0;
        ID_RegRs = 0; ID_RegRt = 0; ID_UseRs = 0; ID_UseRt = 0;
        WB_RegWrite = 0; WBRegRd = 0; Flush = 0;
    endtask

    task automatic set_id(input logic wr, input logic [4:0] rd, input logic ld,
                          input logic urs, input logic [4:0] rs,
                          input logic urt, input logic [4:0] rt);
        ID_Valid = 1; ID_RegWrite = wr; ID_RegRd = rd; ID_MemRead = ld;
        ID_UseRs = urs; ID_RegRs = rs; ID_UseRt = urt; ID_RegRt = rt;
    endtask

    task automatic wb(input logic [4:0] rd);
        WB_RegWrite = 1; WBRegRd = rd;
    endtask

    initial begin
        idle();
        rst_i = 0;
        tick(); tick();
        rst_i = 1;
        #1;
        chk("reset_busy", Busy, 32'h0);
        chk("reset_exmr", {31'd0, EX_MemRead}, 32'h0);
        chk("reset_exrd", {27'd0, EXRegRd}, 32'h0);
        chk("reset_stall", {31'd0, Stall}, 32'h0);
`ifdef HAZARD_STALL_CNT_EN
        chk("reset_stallcnt", StallCnt, 32'h0);
`endif

        // Load-use: lw $5 then add $8 reading $5.
        set_id(1, 5'd5, 1, 1, 5'd1, 0, 5'd0);
        #1 chk("lw_issue_stall", {31'd0, Stall}, 32'h0);
        tick();
        chk("lw_ex_memread", {31'd0, EX_MemRead}, 32'h1);
        chk("lw_ex_rd", {27'd0, EXRegRd}, 32'd5);
        chk("lw_busy", Busy, 32'h20);
        set_id(1, 5'd8, 0, 1, 5'd5, 0, 5'd0);
        #1 chk("loaduse_stall", {31'd0, Stall}, 32'h1);
        tick();
        chk("loaduse_release", {31'd0, Stall}, 32'h0);
        chk("bubble_memread", {31'd0, EX_MemRead}, 32'h0);
        chk("bubble_rd", {27'd0, EXRegRd}, 32'd0);
        tick();
        chk("add_issued_rd", {27'd0, EXRegRd}, 32'd8);
        chk("add_busy", Busy, 32'h120);
        idle(); wb(5'd5); tick();
        wb(5'd8); tick();
        idle();
        chk("retire_all", Busy, 32'h0);

        // No false stall: different register, and register 0.
        set_id(1, 5'd5, 1, 0, 5'd0, 0, 5'd0);
        tick();
        set_id(0, 5'd0, 0, 1, 5'd6, 1, 5'd0);
        #1 chk("nofalse_rs6", {31'd0, Stall}, 32'h0);
        tick();
        set_id(1, 5'd0, 1, 0, 5'd0, 0, 5'd0);
        tick();
        chk("lw0_busy", Busy, 32'h20);
        chk("lw0_exrd", {27'd0, EXRegRd}, 32'd0);
        set_id(0, 5'd0, 0, 1, 5'd0, 1, 5'd0);
        #1 chk("nofalse_r0", {31'd0, Stall}, 32'h0);
        tick();
        idle(); wb(5'd5); tick();
        idle();
        chk("retire5", Busy, 32'h0);

        // Counter: two writers to $7, then retirements, then extra retirement.
        set_id(1, 5'd7, 0, 0, 5'd0, 0, 5'd0);
        tick(); tick();
        idle();
        chk("cnt7_two", Busy, 32'h80);
        wb(5'd7); tick();
        chk("cnt7_one", Busy, 32'h80);
        tick();
        chk("cnt7_zero", Busy, 32'h0);
        tick();
        idle();
        chk("cnt7_nowrap", Busy, 32'h0);

        // Saturation on $3.
        set_id(1, 5'd3, 0, 0, 5'd0, 0, 5'd0);
        tick(); tick(); tick();
        chk("sat_stall", {31'd0, Stall}, 32'h1);
        tick();
        chk("sat_stall_held", {31'd0, Stall}, 32'h1);
        chk("sat_bubble_rd", {27'd0, EXRegRd}, 32'd0);
        wb(5'd3);
        #1 chk("sat_wb_release", {31'd0, Stall}, 32'h0);
        tick();
        WB_RegWrite = 0;
        #1 chk("sat_still_full", {31'd0, Stall}, 32'h1);
        idle(); wb(5'd3); tick(); tick();
        chk("sat_two_left", Busy, 32'h8);
        tick();
        idle();
        chk("sat_drained", Busy, 32'h0);

        // Flush: sub $9 in EX, ID writes $10 with Flush.
        set_id(1, 5'd9, 0, 0, 5'd0, 0, 5'd0);
        tick();
        set_id(1, 5'd10, 0, 0, 5'd0, 0, 5'd0);
        Flush = 1;
        #1 chk("flush_stall", {31'd0, Stall}, 32'h0);
        tick();
        idle();
        chk("flush_busy", Busy, 32'h0);
        chk("flush_exrd", {27'd0, EXRegRd}, 32'd0);
        // Flush suppresses a load-use stall and squashes the load.
        set_id(1, 5'd5, 1, 0, 5'd0, 0, 5'd0);
        tick();
        set_id(1, 5'd10, 0, 1, 5'd5, 0, 5'd0);
        Flush = 1;
        #1 chk("flush_lu_stall", {31'd0, Stall}, 32'h0);
        tick();
        idle();
        chk("flush_lu_busy", Busy, 32'h0);
        chk("flush_lu_exmr", {31'd0, EX_MemRead}, 32'h0);
        // Flush plus WB on the same register: net -2.
        set_id(1, 5'd9, 0, 0, 5'd0, 0, 5'd0);
        tick(); tick();
        idle();
        Flush = 1; wb(5'd9);
        tick();
        idle();
        chk("flush_wb_net2", Busy, 32'h0);

        // Reset mid-operation.
        set_id(1, 5'd4, 0, 0, 5'd0, 0, 5'd0);
        tick(); tick();
        set_id(1, 5'd11, 1, 0, 5'd0, 0, 5'd0);
        tick();
        idle();
        chk("pre_rst_busy", Busy, 32'h810);
        chk("pre_rst_exmr", {31'd0, EX_MemRead}, 32'h1);
        rst_i = 0;
        tick();
        rst_i = 1;
        set_id(0, 5'd0, 0, 1, 5'd11, 0, 5'd0);
        #1;
        chk("rst_busy", Busy, 32'h0);
        chk("rst_exmr", {31'd0, EX_MemRead}, 32'h0);
        chk("rst_exrd", {27'd0, EXRegRd}, 32'd0);
        chk("rst_stall", {31'd0, Stall}, 32'h0);
`ifdef HAZARD_STALL_CNT_EN
        chk("rst_stallcnt", StallCnt, 32'h0);
`endif
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the EX-stage forwarding unit.
- Tracks every in-flight register write from issue (ID→EX) to retirement (WB). Detects load-use hazards that forwarding cannot cover, and drives the pipeline stall.
- Sits in ID. Its stall output holds PC and IF/ID and injects a bubble into ID/EX.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is never tracked.
- CNT_W, 2, width of each per-register pending-write counter; max outstanding writes per register = 2^CNT_W-1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- ID_RegRs  input  5  rs of the instruction in ID.
- ID_RegRt  input  5  rt of the instruction in ID.
- ID_UseRs  input  1  ID instruction reads rs.
- ID_UseRt  input  1  ID instruction reads rt.
- ID_Valid  input  1  ID holds a real instruction.
- ID_RegWrite  input  1  ID instruction writes a register.
- ID_RegRd  input  5  destination of the ID instruction.
- ID_MemRead  input  1  ID instruction is a load.
- WB_RegWrite  input  1  WB-stage write retiring this cycle.
- WBRegRd  input  5  destination retiring in WB.
- Flush  input  1  branch taken; kill the ID instruction and the EX-stage instruction.
- Stall  output  1  hold PC and IF/ID; insert bubble into ID/EX.
- EX_MemRead  output  1  registered: the EX-stage instruction is a load.
- EXRegRd  output  5  registered destination of the EX-stage instruction.
- Busy  output  NUM_REGS  bit r = pending[r] != 0; bit 0 tied 0.

Behaviour:
- State:
  - pending[1..NUM_REGS-1], each CNT_W bits.
  - EX shadow registers: ex_valid, ex_regwrite, ex_memread, ex_rd.
- Reset (rst_i=0 at clk edge):
  - all pending = 0; ex_valid = ex_regwrite = ex_memread = 0; ex_rd = 0.
  - Outputs: Stall=0, EX_MemRead=0, EXRegRd=0, Busy=0.
- Stall is combinational from the current-cycle state and is asserted when ID_Valid and not Flush and any of:
  - (a) load-use: ex_valid and ex_memread and ex_rd!=0, and (ID_UseRs and ID_RegRs==ex_rd) or (ID_UseRt and ID_RegRt==ex_rd).
  - (b) saturation: ID_RegWrite and ID_RegRd!=0 and pending[ID_RegRd] == max, and WB is not retiring ID_RegRd this cycle.
- Issue: accept = ID_Valid and not Stall and not Flush.
  - On accept, the EX shadow loads the ID fields.
  - Otherwise the EX shadow loads a bubble (ex_valid=0).
- Increment: pending[ID_RegRd] +1 on accept when ID_RegWrite and ID_RegRd!=0.
- Decrement: pending[WBRegRd] -1 when WB_RegWrite and WBRegRd!=0 and the counter is nonzero.
  - Decrementing a counter at 0 is ignored; it never wraps.
- Increment and decrement on the same register in the same cycle: counter unchanged.
- Flush: the EX-stage instruction is squashed.
  - If ex_valid and ex_regwrite and ex_rd!=0, pending[ex_rd] -1.
  - This combines additively with a WB decrement on the same register (net -2, floored at 0).
  - ID is not issued; the EX shadow becomes a bubble.
- Writes to or reads of register 0 never stall and never touch counters.
- Load-use stall lasts exactly 1 cycle: the load moves to MEM and the bubble occupies EX, so the WB/MEM forwarding paths cover the dependency.
- Latency: Stall same cycle (combinational); Busy and EX outputs update one cycle after the causing edge.

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- Defined:
  - Adds output StallCnt (32 bits), reset to 0.
  - Increments on every cycle Stall=1; saturates at 0xFFFFFFFF.
  - Flush cycles are not counted.
- Undefined: port absent; no counter logic.

Test Plan:
- Load-use:
  - Stimulus: issue lw $5 (MemRead, Rd=5); next cycle ID add with Rs=5, UseRs=1.
  - Response: Stall=1 for exactly 1 cycle; the following cycle Stall=0, EX_MemRead=0, and add issues.
- No false stall:
  - Stimulus: issue lw $5; next ID uses Rs=6, Rt=0.
  - Response: Stall=0. Also, lw $0 followed by a $0 read gives Stall=0.
- Counter/Busy:
  - Stimulus: issue add $7 twice, then WB_RegWrite, WBRegRd=7 once.
  - Response: Busy[7]=1 with pending=2, then pending=1. A second WB gives Busy[7]=0.
- Saturation (CNT_W=2):
  - Stimulus: three issues to $3 with no WB, then a fourth writer to $3.
  - Response: Stall=1 until a WB to $3 arrives; in the WB cycle Stall=0 and pending stays 3.
- Flush:
  - Stimulus: issue sub $9; next cycle Flush=1 with an ID instruction writing $10.
  - Response: pending[9]=0, pending[10]=0, ex_valid=0, Stall=0.
- Reset mid-operation:
  - Stimulus: pending[4]=2 and a load in EX; assert rst_i=0 for one edge.
  - Response: Busy=0, EX_MemRead=0, EXRegRd=0, Stall=0 (and StallCnt=0 if enabled).
